uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame (LSB first).
REQ-002 Parameter: PRESCALE_W, default 6, width of prescale and edge_cnt.
REQ-003 Port: clk  in  1  receiver oversampling clock; sole clock; all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: rx_in  in  1  serial line, idle high.
REQ-006 Port: par_en / par_typ / prescale  in  1/1/PRESCALE_W  parity enable, parity type (0 even, 1 odd), oversampling ratio.
REQ-007 Port: strt_glitch / par_err / stp_err  in  1/1/1  checker results.
REQ-008 Port: edge_cnt / bit_cnt  out  PRESCALE_W/4  oversample edge index within bit, bit index within frame.
REQ-009 Port: dat_samp_en / deser_en / strt_chk_en / par_chk_en / stp_chk_en  out  1 each  datapath enables.
REQ-010 Port: par_typ_o  out  1  latched parity type to checker.
REQ-011 Port: data_valid / frame_par_err / frame_stp_err  out  1/1/1  end-of-frame status pulses.

Function
REQ-012 States IDLE, START, DATA, PARITY, STOP; one-hot or binary, no other reachable states.
REQ-013 Let P = latched prescale, H = P>>1, "bit end" = edge_cnt==P-1.
REQ-014 edge_cnt increments every clk outside IDLE, wraps P-1 -> 0; held 0 in IDLE.
REQ-015 bit_cnt increments at each bit end, cleared to 0 on entering IDLE; START is bit 0, data bits 1..DATA_W, parity DATA_W+1 if enabled.
REQ-016 IDLE -> START on first clk with rx_in==0; par_en, par_typ, prescale latched on that same edge; later input changes ignored until next IDLE.
REQ-017 prescale values other than 8, 16, 32 latched as 8.
REQ-018 START at bit end: strt_glitch==1 -> IDLE (no status pulse); else -> DATA.
REQ-019 DATA at bit end with bit_cnt==DATA_W -> PARITY if latched par_en else STOP.
REQ-020 PARITY at bit end -> STOP.
REQ-021 STOP at bit end -> IDLE; frame_par_err <= par_err & latched par_en, frame_stp_err <= stp_err, data_valid <= both clear; all three are single-clk pulses on the following cycle.
REQ-022 dat_samp_en = 1 in every state except IDLE.
REQ-023 strt_chk_en / deser_en / stp_chk_en = 1 only when edge_cnt==H+2 in START / DATA / STOP respectively (one clk per bit).
REQ-024 par_chk_en = latched par_en in DATA and PARITY states (level, whole state), else 0.
REQ-025 Falling rx_in on the clk after STOP exit re-enters START with edge_cnt=0 (back-to-back frames, no lost cycles beyond one IDLE clk).
REQ-026 rx_in activity during START/DATA/PARITY/STOP does not alter state except via checker inputs.
REQ-027 Outputs are registered or pure decodes of registered state/counters; no combinational path from rx_in to any output.

Reset
REQ-028 On rst low, immediately: state IDLE, edge_cnt=0, bit_cnt=0, all enables 0, data_valid/frame_par_err/frame_stp_err 0, latched config = par_en 0, par_typ 0, prescale 8.
REQ-029 Reset asserted mid-frame aborts the frame with no status pulse; after release, controller waits for a new falling rx_in.

Verification
REQ-030 P=8, par_en=1, par_typ=0, frame 0xA5 with correct even parity, checkers clean -> deser_en pulses 8 times at edge_cnt=6, data_valid one clk pulse 88 clks after start edge.
REQ-031 P=16, par_en=0, frame 0x3C -> no PARITY state, par_chk_en stays 0, data_valid after 160 clks.
REQ-032 strt_glitch=1 at START bit end -> IDLE, bit_cnt=0, no data_valid/error pulses.
REQ-033 P=8, par_en=1, par_err=1 during STOP -> frame_par_err pulse, data_valid 0; separate run with stp_err=1 -> frame_stp_err pulse, data_valid 0.
REQ-034 Two back-to-back frames, second start bit immediately after stop -> two data_valid pulses, second frame sequenced identically.
REQ-035 rst low at bit_cnt=4 of a frame, prescale changed to 32 before release -> all outputs 0 at once; next frame runs with P=32.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive sequencer. Frames the oversampled serial line into
//            start/data/parity/stop bits and drives datapath/checker enables.
// Revision : 1.0
// ============================================================================
module uart_rx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  par_typ_o,
  output logic                  data_valid,
  output logic                  frame_par_err,
  output logic                  frame_stp_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [PRESCALE_W-1:0] C_PRE_8     = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] C_PRE_16    = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] C_PRE_32    = PRESCALE_W'(32);
  localparam logic [PRESCALE_W-1:0] C_ONE       = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] C_TWO       = PRESCALE_W'(2);
  localparam logic [3:0]            C_LAST_DATA = 4'(DATA_W);

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d, pre_sel, tgt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    bit_end;
  logic                    dat_samp_en_q, dat_samp_en_d;
  logic                    deser_en_q, deser_en_d;
  logic                    strt_chk_en_q, strt_chk_en_d;
  logic                    par_chk_en_q, par_chk_en_d;
  logic                    stp_chk_en_q, stp_chk_en_d;
  logic                    data_valid_q, data_valid_d;
  logic                    frame_par_err_q, frame_par_err_d;
  logic                    frame_stp_err_q, frame_stp_err_d;

  // Unsupported oversampling ratios fall back to 8.
  always_comb begin
    case (prescale)
      C_PRE_16: pre_sel = C_PRE_16;
      C_PRE_32: pre_sel = C_PRE_32;
      default:  pre_sel = C_PRE_8;
    endcase
  end

  assign bit_end = (edge_cnt_q == (pre_q - C_ONE));

  always_comb begin
    state_d         = state_q;
    edge_cnt_d      = edge_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    pre_d           = pre_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    data_valid_d    = 1'b0;
    frame_par_err_d = 1'b0;
    frame_stp_err_d = 1'b0;

    if (state_q == IDLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      if (!rx_in) begin
        state_d   = START;
        pre_d     = pre_sel;
        par_en_d  = par_en;
        par_typ_d = par_typ;
      end
    end else if (bit_end) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
    end else begin
      edge_cnt_d = edge_cnt_q + C_ONE;
    end

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == C_LAST_DATA)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d         = IDLE;
          bit_cnt_d       = '0;
          frame_par_err_d = par_err & par_en_q;
          frame_stp_err_d = stp_err;
          data_valid_d    = ~(par_err & par_en_q) & ~stp_err;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Enables are decoded from the next state/edge so the registered copies
  // line up with the edge_cnt value they qualify.
  assign tgt_d = (pre_d >> 1) + C_TWO;

  always_comb begin
    dat_samp_en_d = (state_d != IDLE);
    strt_chk_en_d = (state_d == START) && (edge_cnt_d == tgt_d);
    deser_en_d    = (state_d == DATA)  && (edge_cnt_d == tgt_d);
    stp_chk_en_d  = (state_d == STOP)  && (edge_cnt_d == tgt_d);
    par_chk_en_d  = par_en_d && ((state_d == DATA) || (state_d == PARITY));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      edge_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      pre_q           <= C_PRE_8;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      dat_samp_en_q   <= 1'b0;
      deser_en_q      <= 1'b0;
      strt_chk_en_q   <= 1'b0;
      par_chk_en_q    <= 1'b0;
      stp_chk_en_q    <= 1'b0;
      data_valid_q    <= 1'b0;
      frame_par_err_q <= 1'b0;
      frame_stp_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      edge_cnt_q      <= edge_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      pre_q           <= pre_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      dat_samp_en_q   <= dat_samp_en_d;
      deser_en_q      <= deser_en_d;
      strt_chk_en_q   <= strt_chk_en_d;
      par_chk_en_q    <= par_chk_en_d;
      stp_chk_en_q    <= stp_chk_en_d;
      data_valid_q    <= data_valid_d;
      frame_par_err_q <= frame_par_err_d;
      frame_stp_err_q <= frame_stp_err_d;
    end
  end

  assign edge_cnt      = edge_cnt_q;
  assign bit_cnt       = bit_cnt_q;
  assign dat_samp_en   = dat_samp_en_q;
  assign deser_en      = deser_en_q;
  assign strt_chk_en   = strt_chk_en_q;
  assign par_chk_en    = par_chk_en_q;
  assign stp_chk_en    = stp_chk_en_q;
  assign par_typ_o     = par_typ_q;
  assign data_valid    = data_valid_q;
  assign frame_par_err = frame_par_err_q;
  assign frame_stp_err = frame_stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Bench for uart_rx_ctrl: frame-level reference model compared every
//            cycle, directed timing pins and randomized line/config stimulus.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_ctrl;
  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;

  logic                  clk         = 1'b0;
  logic                  rst         = 1'b1;
  logic                  rx_in       = 1'b1;
  logic                  par_en      = 1'b0;
  logic                  par_typ     = 1'b0;
  logic [PRESCALE_W-1:0] prescale    = 6'd8;
  logic                  strt_glitch = 1'b0;
  logic                  par_err     = 1'b0;
  logic                  stp_err     = 1'b0;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic par_typ_o, data_valid, frame_par_err, frame_stp_err;

  uart_rx_ctrl #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .prescale(prescale), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .par_typ_o(par_typ_o), .data_valid(data_valid), .frame_par_err(frame_par_err),
    .frame_stp_err(frame_stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: a frame is a count k of clocks since the start edge;
  // edge index and bit index follow from k by division.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_P      = 8;
  bit m_pe     = 1'b0;
  bit m_pt     = 1'b0;
  bit m_dv     = 1'b0;
  bit m_fpe    = 1'b0;
  bit m_fse    = 1'b0;

  function automatic int map_prescale(input logic [PRESCALE_W-1:0] v);
    if (v == 6'd8 || v == 6'd16 || v == 6'd32) return int'(v);
    return 8;
  endfunction

  function automatic int frame_len(input int p, input bit pe);
    return (DATA_W + 2 + (pe ? 1 : 0)) * p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_k <= 0; m_P <= 8; m_pe <= 1'b0; m_pt <= 1'b0;
      m_dv <= 1'b0; m_fpe <= 1'b0; m_fse <= 1'b0;
    end else begin
      m_dv <= 1'b0; m_fpe <= 1'b0; m_fse <= 1'b0;
      if (!m_active) begin
        if (!rx_in) begin
          m_active <= 1'b1; m_k <= 0; m_P <= map_prescale(prescale);
          m_pe <= par_en; m_pt <= par_typ;
        end
      end else if (m_k == m_P - 1 && strt_glitch) begin
        m_active <= 1'b0;
      end else if (m_k == frame_len(m_P, m_pe) - 1) begin
        m_active <= 1'b0;
        m_fpe    <= par_err && m_pe;
        m_fse    <= stp_err;
        m_dv     <= !(par_err && m_pe) && !stp_err;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_start, last_start, prev_start, n_dv, last_dv, n_fpe, n_fse;
  int n_deser, n_deser6, n_parchk, max_bit;
  bit prev_samp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    int e_edge, e_bit, tgt;
    bit st, dt, pr, sp;
    e_edge = 0; e_bit = 0; tgt = -1; st = 0; dt = 0; pr = 0; sp = 0;
    if (m_active) begin
      e_edge = m_k % m_P;
      e_bit  = m_k / m_P;
      tgt    = m_P / 2 + 2;
      st     = (e_bit == 0);
      dt     = (e_bit >= 1) && (e_bit <= DATA_W);
      pr     = m_pe && (e_bit == DATA_W + 1);
      sp     = !st && !dt && !pr;
    end
    chk("edge_cnt",      int'(edge_cnt),      e_edge);
    chk("bit_cnt",       int'(bit_cnt),       e_bit);
    chk("dat_samp_en",   int'(dat_samp_en),   int'(m_active));
    chk("strt_chk_en",   int'(strt_chk_en),   (st && e_edge == tgt) ? 1 : 0);
    chk("deser_en",      int'(deser_en),      (dt && e_edge == tgt) ? 1 : 0);
    chk("stp_chk_en",    int'(stp_chk_en),    (sp && e_edge == tgt) ? 1 : 0);
    chk("par_chk_en",    int'(par_chk_en),    (m_pe && (dt || pr)) ? 1 : 0);
    chk("par_typ_o",     int'(par_typ_o),     int'(m_pt));
    chk("data_valid",    int'(data_valid),    int'(m_dv));
    chk("frame_par_err", int'(frame_par_err), int'(m_fpe));
    chk("frame_stp_err", int'(frame_stp_err), int'(m_fse));
  endtask

  task automatic monitor();
    if (dat_samp_en && !prev_samp && edge_cnt == 0 && bit_cnt == 0) begin
      prev_start = last_start; last_start = cyc; n_start++;
    end
    prev_samp = dat_samp_en;
    if (data_valid) begin n_dv++; last_dv = cyc; end
    if (frame_par_err) n_fpe++;
    if (frame_stp_err) n_fse++;
    if (deser_en) n_deser++;
    if (deser_en && edge_cnt == 6'd6) n_deser6++;
    if (par_chk_en) n_parchk++;
    if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
  endtask

  task automatic clear_mon();
    n_start = 0; last_start = 0; prev_start = 0; n_dv = 0; last_dv = 0;
    n_fpe = 0; n_fse = 0; n_deser = 0; n_deser6 = 0; n_parchk = 0; max_bit = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    monitor();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input int p, input bit pe, input bit pt);
    rx_in = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < DATA_W; i++) begin
      rx_in = data[i];
      repeat (p) tick();
    end
    if (pe) begin
      rx_in = pt ? ~^data : ^data;
      repeat (p) tick();
    end
    rx_in = 1'b1;
    repeat (p) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_edge_cnt"},   int'(edge_cnt), 0);
    chk({tag, "_bit_cnt"},    int'(bit_cnt), 0);
    chk({tag, "_enables"},    int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    chk({tag, "_par_typ_o"},  int'(par_typ_o), 0);
    chk({tag, "_status"},     int'({data_valid, frame_par_err, frame_stp_err}), 0);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int rst_hold;
    clear_mon();
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) tick();
    rst = 1'b1;
    idle(3);

    // 0xA5, P=8, even parity: 11 bits x 8 clocks.
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    clear_mon();
    send_frame(8'hA5, 8, 1'b1, 1'b0);
    idle(4);
    chk("A_dv_count",       n_dv, 1);
    chk("A_dv_latency",     last_dv - last_start, 88);
    chk("A_deser_count",    n_deser, 8);
    chk("A_deser_at_edge6", n_deser6, 8);
    chk("A_par_chk_cycles", n_parchk, 72);
    chk("A_err_pulses",     n_fpe + n_fse, 0);

    // 0x3C, P=16, no parity: 10 bits x 16 clocks.
    prescale = 6'd16; par_en = 1'b0;
    clear_mon();
    send_frame(8'h3C, 16, 1'b0, 1'b0);
    idle(4);
    chk("B_dv_count",       n_dv, 1);
    chk("B_dv_latency",     last_dv - last_start, 160);
    chk("B_par_chk_cycles", n_parchk, 0);
    chk("B_max_bit",        max_bit, 9);
    chk("B_deser_count",    n_deser, 8);

    // Start-bit glitch aborts the frame silently.
    prescale = 6'd8; par_en = 1'b1;
    clear_mon();
    rx_in = 1'b0; strt_glitch = 1'b1;
    repeat (8) tick();
    chk("C_still_in_start", int'(dat_samp_en), 1);
    tick();
    chk("C_bit_cnt_after", int'(bit_cnt), 0);
    chk("C_idle_after",    int'(dat_samp_en), 0);
    rx_in = 1'b1; strt_glitch = 1'b0;
    idle(10);
    chk("C_no_status", n_dv + n_fpe + n_fse, 0);
    chk("C_no_deser",  n_deser, 0);

    // Parity error at stop, then stop error in a separate frame.
    clear_mon();
    par_err = 1'b1;
    send_frame(8'h5C, 8, 1'b1, 1'b0);
    tick();
    par_err = 1'b0;
    idle(4);
    chk("D_par_err_pulse", n_fpe, 1);
    chk("D_par_err_no_dv", n_dv, 0);
    clear_mon();
    stp_err = 1'b1;
    send_frame(8'hC3, 8, 1'b1, 1'b0);
    tick();
    stp_err = 1'b0;
    idle(4);
    chk("D_stp_err_pulse", n_fse, 1);
    chk("D_stp_err_no_dv", n_dv, 0);
    chk("D_stp_err_no_pe", n_fpe, 0);

    // Back-to-back frames: one IDLE clock between them.
    clear_mon();
    send_frame(8'h96, 8, 1'b1, 1'b0);
    send_frame(8'h69, 8, 1'b1, 1'b0);
    idle(6);
    chk("E_dv_count",      n_dv, 2);
    chk("E_start_count",   n_start, 2);
    chk("E_start_spacing", last_start - prev_start, 89);
    chk("E_dv_latency2",   last_dv - last_start, 88);

    // Reset mid-frame, new prescale takes effect for the next frame.
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
    clear_mon();
    rx_in = 1'b0;
    repeat (8) tick();
    rx_in = 1'b1;
    budget = 200;
    while (bit_cnt != 4'd4 && budget > 0) begin
      tick();
      budget--;
    end
    chk("F_reach_bit4", int'(bit_cnt), 4);
    prescale = 6'd32; par_en = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("F_reset");
    repeat (2) tick();
    rst = 1'b1;
    idle(4);
    chk("F_aborted_no_dv", n_dv + n_fpe + n_fse, 0);
    clear_mon();
    send_frame(8'h5A, 32, 1'b0, 1'b1);
    idle(4);
    chk("F_dv_count",   n_dv, 1);
    chk("F_dv_latency", last_dv - last_start, 320);

    // Randomized line, config and checker inputs with occasional async reset.
    rst_hold = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      rx_in   = ($urandom_range(0, 9) < 7);
      par_en  = 1'($urandom_range(0, 1));
      par_typ = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       prescale = 6'd8;
        1:       prescale = 6'd16;
        2:       prescale = 6'd32;
        default: prescale = 6'($urandom_range(0, 63));
      endcase
      strt_glitch = ($urandom_range(0, 7) == 0);
      par_err     = ($urandom_range(0, 3) == 0);
      stp_err     = ($urandom_range(0, 3) == 0);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 2999) == 0) begin
        #2 rst = 1'b0;
        rst_hold = 3;
      end
    end
    rst = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
